fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage that sits directly upstream of the X-stage pipeline latches. It owns the program counter and issues in-order requests to an instruction memory with variable latency. Returned instructions are buffered with their PCs in a small queue and presented to X over a valid/ready handshake. Redirects from X (taken branch/jump, `alu_X` target) flush the queue and discard in-flight responses.

## Interface
- `DEPTH`, 4: queue entries (power of two, ≥2).
- `MAX_OUT`, 2: maximum outstanding IMEM requests (1..DEPTH).
- `RESET_PC`, 32'h0000_0000: PC after reset.
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `redir_valid`  in  1  redirect request from X control (pc_F_sel).
- `redir_pc`  in  32  redirect target.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  IMEM accepts request.
- `imem_req_addr`  out  32  fetch address (current PC).
- `imem_resp_valid`  in  1  in-order response, always accepted.
- `imem_resp_data`  in  32  instruction word.
- `out_valid`  out  1  queue head valid.
- `out_ready`  in  1  X latch accepts head.
- `out_pc`  out  32  head PC.
- `out_inst`  out  32  head instruction.
- `out_misalign`  out  1  head is a misaligned-target marker (only with FETCH_MISALIGN_EN).

## Operation
- State: `pc`, `outstanding` (0..MAX_OUT), `drop_cnt` (0..MAX_OUT), queue of {pc, inst, misalign}, `halted` (macro only).
- Issue condition: `imem_req_valid = !redir_valid && !halted && outstanding < MAX_OUT && (outstanding - drop_cnt) + count < DEPTH`. On accept: `pc <= pc + 4` (wraps mod 2^32), `outstanding++`, and the pushed-PC shadow FIFO records `pc`.
- Response: `outstanding--`; if `drop_cnt != 0` the word is discarded and `drop_cnt--`, else it is pushed with its recorded PC.
- Pop on `out_valid && out_ready`.
- Redirect (`redir_valid=1`): no request issued that cycle; queue emptied; `pc <= redir_pc`; `drop_cnt <= outstanding_next` (all requests still in flight after this cycle's response, if any). A same-cycle pop completes before the flush.
- The credit rule guarantees no push to a full queue; overflow is an assertion failure.
- Back-to-back redirects: the latest wins; drop counting accumulates correctly.

## Timing
- Reset values: `pc=RESET_PC`, `outstanding=0`, `drop_cnt=0`, queue empty, `halted=0`, `imem_req_valid=0` while rst low, `out_valid=0`, `out_pc=0`, `out_inst=0`, `out_misalign=0`.
- First request is issued in the first cycle after reset deassertion.
- Latency: response in cycle t gives `out_valid=1` in t+1 (registered queue, no bypass).
- Redirect in cycle t gives the first request to `redir_pc` in t+1.
- Sustained throughput is 1 instr/cycle when IMEM latency ≤ MAX_OUT and X is ready.
- Reset asserted mid-operation abandons all state. IMEM must also be reset.

## Configuration
- `FETCH_MISALIGN_EN` defined:
  - A redirect with `redir_pc[1:0] != 0` issues no request.
  - It pushes one entry {pc=redir_pc, inst=32'h0000_0013, misalign=1} once in-flight responses have drained.
  - It sets `halted=1` until the next redirect.
- Not defined:
  - `redir_pc[1:0]` is forced to 2'b00.
  - `out_misalign` is tied to 0.
  - There is no `halted` state.

## Structure
- `fetch_pkg` holds:
  - the `fetch_entry_t` struct {pc[31:0], inst[31:0], misalign};
  - the `NOP_INST` constant (32'h0000_0013);
  - the default `RESET_PC`.
- Sub-module `fetch_fifo` is a parameterised synchronous FIFO of `fetch_entry_t` with push, pop, flush, count, full and empty. It is instantiated once for the queue; the PC shadow is a small FIFO of depth MAX_OUT.

## Test plan
- Reset with RESET_PC=0 and IMEM latency 1, X always ready:
  - Requests go to 0,4,8,…
  - `out_pc` = 0,4,8 on consecutive cycles from cycle 3.
- `out_ready=0` held for 10 cycles:
  - Exactly DEPTH=4 entries are buffered and requests stop.
  - After release, PCs 0..12 drain in order with no loss.
- IMEM latency 3, MAX_OUT=2: `outstanding` never exceeds 2, with 2 instructions per 3 cycles.
- Redirect to 0x100 with 2 requests outstanding:
  - Both responses are dropped.
  - The next `out_pc` is 0x100 with the IMEM word at 0x100.
- Redirect and pop in the same cycle:
  - The popped entry is consumed once.
  - The queue is then empty and the next request is to the target.
- With the macro defined, redirect to 0x102:
  - The single entry {0x102, 0x00000013, misalign=1} appears and no further requests are issued.
  - A redirect to 0x200 resumes fetch.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared entry type and constants for the fetch stage
package fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        misalign;
    } fetch_entry_t;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO of fetch entries with flush
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  fetch_entry_t               push_data_i,
    input  logic                       pop_i,
    output fetch_entry_t               head_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] rd_q, wr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_q];
    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign do_push = push_i && !full_o && !flush_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= push_data_i;
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC owner and instruction queue feeding X; FETCH_MISALIGN_EN adds misaligned-target markers
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter int          MAX_OUT  = 2,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redir_valid,
    input  logic [31:0] redir_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        out_misalign
);
    localparam int OW   = $clog2(MAX_OUT + 1);
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int SUMW = CW + 1;
    localparam int SW   = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    logic [31:0]     pc_q, pc_d;
    logic [OW-1:0]   outst_q, outst_d, drop_q, drop_d, outst_eff;
    logic [SW-1:0]   sh_rd_q, sh_rd_d, sh_wr_q, sh_wr_d;
    logic [31:0]     shadow_q [MAX_OUT];
    logic [SUMW-1:0] credit_used;

    fetch_entry_t    q_head, q_push_data;
    logic [CW-1:0]   q_count;
    logic            q_push, q_full, q_empty;
    logic            accept, resp_drop, resp_keep, stall, marker_push;
    logic [31:0]     target;

`ifdef FETCH_MISALIGN_EN
    logic halted_q, halted_d, marker_q, marker_d;
    assign target      = redir_pc;
    assign stall       = halted_q;
    assign marker_push = marker_q && (outst_q == '0) && !redir_valid;
`else
    assign target      = redir_pc & 32'hFFFF_FFFC;
    assign stall       = 1'b0;
    assign marker_push = 1'b0;
`endif

    function automatic logic [SW-1:0] sh_next(input logic [SW-1:0] p);
        return (p == SW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
    endfunction

    // A response arriving this cycle frees its slot at once, so latency <= MAX_OUT sustains full rate.
    assign outst_eff      = outst_q - OW'(imem_resp_valid);
    assign credit_used    = SUMW'(outst_q - drop_q) + SUMW'(q_count);
    assign imem_req_valid = rst && !redir_valid && !stall && (outst_eff < OW'(MAX_OUT))
                            && (credit_used < SUMW'(DEPTH));
    assign imem_req_addr  = pc_q;
    assign accept         = imem_req_valid && imem_req_ready;
    assign resp_drop      = imem_resp_valid && (drop_q != '0);
    assign resp_keep      = imem_resp_valid && (drop_q == '0) && !redir_valid;
    assign q_push         = resp_keep || marker_push;
    assign q_push_data    = marker_push ? '{pc: pc_q, inst: NOP_INST, misalign: 1'b1}
                                        : '{pc: shadow_q[sh_rd_q], inst: imem_resp_data, misalign: 1'b0};

    always_comb begin
        outst_d = outst_q + OW'(accept) - OW'(imem_resp_valid);
        drop_d  = redir_valid ? outst_d : drop_q - OW'(resp_drop);
        pc_d    = redir_valid ? target : (accept ? pc_q + 32'd4 : pc_q);
        sh_wr_d = accept ? sh_next(sh_wr_q) : sh_wr_q;
        sh_rd_d = imem_resp_valid ? sh_next(sh_rd_q) : sh_rd_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q    <= RESET_PC;
            outst_q <= '0;
            drop_q  <= '0;
            sh_rd_q <= '0;
            sh_wr_q <= '0;
        end else begin
            pc_q    <= pc_d;
            outst_q <= outst_d;
            drop_q  <= drop_d;
            sh_rd_q <= sh_rd_d;
            sh_wr_q <= sh_wr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) shadow_q[sh_wr_q] <= pc_q;
    end

`ifdef FETCH_MISALIGN_EN
    // A misaligned target parks fetch and emits one marker once old responses drain.
    always_comb begin
        halted_d = halted_q;
        marker_d = marker_q && !marker_push;
        if (redir_valid) begin
            halted_d = (target[1:0] != 2'b00);
            marker_d = (target[1:0] != 2'b00);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            halted_q <= 1'b0;
            marker_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
            marker_q <= marker_d;
        end
    end
`endif

    fetch_fifo #(.DEPTH(DEPTH)) u_queue (
        .clk        (clk),
        .rst_n      (rst),
        .flush_i    (redir_valid),
        .push_i     (q_push),
        .push_data_i(q_push_data),
        .pop_i      (out_ready),
        .head_o     (q_head),
        .count_o    (q_count),
        .full_o     (q_full),
        .empty_o    (q_empty)
    );

    queue_overflow_a: assert property (@(posedge clk) disable iff (!rst) !(q_push && q_full));

    assign out_valid    = !q_empty;
    assign out_pc       = q_empty ? '0 : q_head.pc;
    assign out_inst     = q_empty ? '0 : q_head.inst;
    assign out_misalign = !q_empty && q_head.misalign;

endmodule
